spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
Serial front end of the SPI slave. It deserialises MOSI frames into 10-bit command words for the single-port RAM stage (rx_data/rx_valid). It also serialises the 8-bit read data returned by that stage (tx_data/tx_valid) onto MISO. It sits directly upstream of the memory block and closes the read loop back to the master.

Parameters:
FRAME_W, 10, width of command word delivered to memory (2 opcode bits + ADDR_SIZE payload)
ADDR_SIZE, 8, payload/address and read-data width

Ports:
clk  input  1  system clock; also the SPI bit clock; MOSI sampled on rising edge
rst  input  1  asynchronous, active-high reset
SS_n  input  1  slave select, active low; frame boundary
MOSI  input  1  serial data from master, MSB first
rx_data  output  FRAME_W  assembled command word to memory (din)
rx_valid  output  1  one-cycle strobe: rx_data is valid
tx_data  input  ADDR_SIZE  read data from memory (dout)
tx_valid  input  1  memory read data valid
MISO  output  1  serial data to master, MSB first

Behaviour:
- Reset (rst=1, async): state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_done=0, tx shift reg=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 sampled -> CHK_CMD; else stay.
- CHK_CMD: SS_n=1 -> IDLE. Otherwise sample MOSI as command bit: 0 -> WRITE; 1 and rd_addr_done=0 -> READ_ADD; 1 and rd_addr_done=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift FRAME_W bits, MSB first, one per clk, into the rx shift register.
- After the FRAME_W-th bit is sampled, the next cycle drives rx_data=shift reg and rx_valid=1 for exactly one cycle. rx_data holds until the next strobe.
- After the strobe in READ_ADD, set rd_addr_done=1.
- After the strobe in WRITE or READ_ADD, ignore MOSI and remain until SS_n=1, then go to IDLE.
- READ_DATA, after the strobe: wait for the first cycle with tx_valid=1 and capture tx_data into the tx shift register.
  - tx_valid may stay high for several cycles because memory holds it while din[9:8]=11. Capture only once per frame.
  - On the following ADDR_SIZE cycles, drive MISO with tx shift reg MSB first, one bit per cycle.
  - After the last bit, MISO=0 and rd_addr_done=0, then wait for SS_n=1 -> IDLE.
- MISO=0 whenever no read bit is being shifted.
- SS_n=1 mid-frame, any state: next cycle state=IDLE, bit counter=0, no rx_valid, MISO=0, rd_addr_done unchanged. A partial read-data shift is abandoned, and rd_addr_done stays 1 so the master can retry.
- Read-data frame with rd_addr_done=0 cannot occur; the command bit then selects READ_ADD.
- Extra MOSI bits beyond FRAME_W within one SS_n low period are ignored. One command word per frame.
- rx_valid never asserts in the same cycle as the state leaving IDLE.
- Latency: SS_n low edge to rx_valid = 1 (CHK_CMD) + FRAME_W + 1 cycles = 12 cycles at default.

Test Plan:
- Write address: SS_n=0, MOSI=0, then 00_0011_1100 -> rx_data=0x03C and rx_valid high for exactly 1 cycle, 12 cycles after SS_n fall. MISO stays 0.
- Write data: MOSI=0, then 01_1010_0101 -> rx_data=0x1A5 with rx_valid pulse. rd_addr_done unchanged.
- Read address: MOSI=1, then 10_0011_1100 -> rx_data=0x23C and rx_valid pulse. Internal rd_addr_done=1.
- Read data: MOSI=1, then 11_0000_0000 -> rx_data=0x300. Memory model returns tx_data=0xA5 with tx_valid held 3 cycles -> MISO=1,0,1,0,0,1,0,1 on 8 consecutive cycles, captured once. Then rd_addr_done=0, and the next read command enters READ_ADD.
- Abort: SS_n raised after 5 payload bits in WRITE -> no rx_valid, state IDLE next cycle. A following full frame decodes correctly.
- Reset mid-read: rst=1 during MISO shift -> MISO=0, rx_valid=0, rd_addr_done=0 immediately without waiting for a clk edge.

Source files
------------

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave serial front end: MOSI frames to command words, read data to MISO.
// Command bit picks the path; a completed read-address frame arms the next read command for data return.
module spi_slave_if #(
  parameter int FRAME_W   = 10,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic [FRAME_W-1:0]   rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 MISO
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam int TXC_W = $clog2(ADDR_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_W);
  localparam logic [TXC_W-1:0] TX_BITS_M1 = TXC_W'(ADDR_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]     bit_cnt;
  logic                 frame_done;
  logic [FRAME_W-1:0]   rx_shift;
  logic                 rd_addr_done;
  logic [ADDR_SIZE-1:0] tx_shift;
  logic [TXC_W-1:0]     tx_cnt;
  logic                 tx_loaded;
  logic                 tx_busy;

  logic clr;
  logic shift_en;
  logic strobe;
  logic tx_load;
  logic tx_step;
  logic tx_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    shift_en  = 1'b0;
    strobe    = 1'b0;
    tx_load   = 1'b0;
    tx_step   = 1'b0;
    tx_end    = 1'b0;
    case (state)
      IDLE: begin
        clr = 1'b1;
        if (!SS_n) begin
          state_nxt = CHK_CMD;
        end
      end
      CHK_CMD: begin
        if (SS_n) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end else if (!MOSI) begin
          state_nxt = WRITE;
        end else if (rd_addr_done) begin
          state_nxt = READ_DATA;
        end else begin
          state_nxt = READ_ADD;
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        // Deselect wins over everything, including a strobe that is due this cycle.
        if (SS_n) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end else if (bit_cnt != LAST_BIT) begin
          shift_en = 1'b1;
        end else if (!frame_done) begin
          strobe = 1'b1;
        end else if (state == READ_DATA) begin
          if (!tx_loaded) begin
            tx_load = tx_valid;
          end else if (tx_busy) begin
            if (tx_cnt != '0) begin
              tx_step = 1'b1;
            end else begin
              tx_end = 1'b1;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        clr       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_shift     <= '0;
      bit_cnt      <= '0;
      frame_done   <= 1'b0;
      rd_addr_done <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      tx_loaded    <= 1'b0;
      tx_busy      <= 1'b0;
      MISO         <= 1'b0;
    end else begin
      rx_valid <= strobe;
      if (strobe) begin
        rx_data <= rx_shift;
      end
      if (clr) begin
        bit_cnt    <= '0;
        frame_done <= 1'b0;
        tx_loaded  <= 1'b0;
        tx_busy    <= 1'b0;
        tx_cnt     <= '0;
        MISO       <= 1'b0;
      end else begin
        if (shift_en) begin
          rx_shift <= {rx_shift[FRAME_W-2:0], MOSI};
          bit_cnt  <= bit_cnt + 1'b1;
        end
        if (strobe) begin
          frame_done <= 1'b1;
          if (state == READ_ADD) begin
            rd_addr_done <= 1'b1;
          end
        end
        // tx_loaded blocks a second capture while memory keeps tx_valid high.
        if (tx_load) begin
          tx_loaded <= 1'b1;
          tx_busy   <= 1'b1;
          MISO      <= tx_data[ADDR_SIZE-1];
          tx_shift  <= {tx_data[ADDR_SIZE-2:0], 1'b0};
          tx_cnt    <= TX_BITS_M1;
        end
        if (tx_step) begin
          MISO     <= tx_shift[ADDR_SIZE-1];
          tx_shift <= {tx_shift[ADDR_SIZE-2:0], 1'b0};
          tx_cnt   <= tx_cnt - 1'b1;
        end
        if (tx_end) begin
          MISO         <= 1'b0;
          tx_busy      <= 1'b0;
          rd_addr_done <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - randomized frame-level check of spi_slave_if against a cycle-indexed frame model.
// Each frame is planned up front; expected outputs come from the frame's cycle index only.
module tb_spi_slave_if;

  logic       clk;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       MISO;

  int         n_vec;
  int         n_err;
  logic       rd_done_m;
  logic [9:0] exp_rx;

  spi_slave_if #(.FRAME_W(10), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .MISO     (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Cycle k: inputs applied before posedge k, outputs checked after it.
  // k=0 SS_n first low, k=1 command bit, k=2..11 payload, strobe visible after k=12.
  task automatic run_frame(input logic cmd, input logic [9:0] payload, input int len,
                           input int gap, input int d, input int hold,
                           input logic [7:0] dout, input int rst_k);
    logic rd_frame;
    logic full;
    logic mem_rsp;
    logic captured;
    logic exp_miso;
    int   cap;
    rd_frame = cmd && rd_done_m;
    full     = (len >= 13);
    cap      = 12 + d;
    mem_rsp  = full && (payload[9:8] == 2'b11);
    captured = rd_frame && mem_rsp && (hold >= 1) && (cap < len);
    for (int k = 0; k < len + gap; k++) begin
      SS_n = (k < len) ? 1'b0 : 1'b1;
      if (k == 1) MOSI = cmd;
      else if (k >= 2 && k <= 11) MOSI = payload[11-k];
      else MOSI = 1'($urandom);
      tx_valid = mem_rsp && (k >= cap) && (k < cap + hold);
      tx_data  = tx_valid ? dout : 8'($urandom);
      tick();
      if (full && k == 12) exp_rx = payload;
      exp_miso = (captured && k >= cap && k < cap + 8 && k < len) ? dout[7-(k-cap)] : 1'b0;
      check("rx_valid", {31'd0, rx_valid}, {31'd0, (full && k == 12)});
      check("rx_data", {22'd0, rx_data}, {22'd0, exp_rx});
      check("miso", {31'd0, MISO}, {31'd0, exp_miso});
      if (k == rst_k) begin
        #2 rst = 1'b1;
        #1;
        check("rst_miso", {31'd0, MISO}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {22'd0, rx_data}, 32'd0);
        rd_done_m = 1'b0;
        exp_rx    = '0;
        SS_n      = 1'b1;
        tx_valid  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    tx_valid = 1'b0;
    if (cmd && !rd_frame && full) rd_done_m = 1'b1;
    if (captured && (cap + 8 < len)) rd_done_m = 1'b0;
  endtask

  initial begin
    logic       cmd;
    logic [9:0] payload;
    int         len;
    n_vec     = 0;
    n_err     = 0;
    rd_done_m = 1'b0;
    exp_rx    = '0;
    rst       = 1'b1;
    SS_n      = 1'b1;
    MOSI      = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    #1;
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {22'd0, rx_data}, 32'd0);
    check("reset_miso", {31'd0, MISO}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_frame(1'b0, 10'h03C, 14, 2, 1, 1, 8'h00, -1);
    run_frame(1'b0, 10'h1A5, 14, 1, 1, 1, 8'h00, -1);
    run_frame(1'b1, 10'h23C, 14, 2, 1, 1, 8'h00, -1);
    run_frame(1'b1, 10'h300, 24, 2, 1, 3, 8'hA5, -1);
    run_frame(1'b1, 10'h3C5, 26, 2, 1, 2, 8'h5A, -1);
    run_frame(1'b0, 10'h0F0, 7, 1, 1, 1, 8'h00, -1);
    run_frame(1'b0, 10'h0F0, 14, 1, 1, 1, 8'h00, -1);
    run_frame(1'b1, 10'h3FF, 30, 2, 2, 2, 8'hFF, 16);
    run_frame(1'b1, 10'h300, 26, 2, 1, 3, 8'h77, -1);
    run_frame(1'b1, 10'h3E1, 25, 2, 2, 4, 8'hC3, -1);

    for (int i = 0; i < 60; i++) begin
      cmd = 1'($urandom);
      if (!cmd) payload = {1'b0, 9'($urandom)};
      else if (!rd_done_m) payload = {2'b10, 8'($urandom)};
      else payload = {2'b11, 8'($urandom)};
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 12);
      else len = 13 + $urandom_range(0, 20);
      run_frame(cmd, payload, len, $urandom_range(1, 3), $urandom_range(1, 3),
                $urandom_range(1, 4), 8'($urandom), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
